// File: rtl/scanline_fetcher_if.sv
// scanline_fetcher_if: read-request channel between the scanline
// fetcher (master) and the PSRAM controller (slave).
interface scanline_fetcher_if;
    logic        stb;
    logic        we;
    logic [23:0] addr;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    modport master (
        output stb, we, addr,
        input  busy, done, dout
    );

    modport slave (
        input  stb, we, addr,
        output busy, done, dout
    );
endinterface

// File: rtl/scanline_fetcher.sv
// scanline_fetcher: fetches the next display line from PSRAM into a back
// bank while the front bank feeds registered pixel colours to the display.
module scanline_fetcher #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          LINE_WORDS = 640
) (
    input  logic                      clk_100mhz,
    input  logic                      rstn_i,
    input  logic                      i_line_req,
    input  logic [8:0]                i_line_num,
    input  logic                      i_swap,
    output logic                      o_line_ready,
    scanline_fetcher_if.master        psram,
    input  logic [9:0]                i_pix_x,
    output logic [11:0]               o_pix_color,
    output logic [1:0]                o_err
);
    localparam int            IW   = $clog2(LINE_WORDS);
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          front_sel;
    logic [IW-1:0] idx;
    logic [23:0]   line_base;
    logic          start;
    logic          issue;
    logic          wr;
    logic          last;
    logic          drop;
    logic          underrun;
    logic [IW-1:0] rd_idx;
    logic          unused_hi;

    logic [11:0] bank0 [LINE_WORDS];
    logic [11:0] bank1 [LINE_WORDS];

    assign last         = (idx == LAST);
    assign drop         = i_line_req && (state == REQ || state == WAIT);
    assign underrun     = i_swap && (state != DONE);
    assign o_line_ready = (state == DONE);
    assign psram.we     = 1'b0;
    assign rd_idx       = i_pix_x[IW-1:0];
    // Upper nibble of each PSRAM word carries no colour.
    assign unused_hi    = ^psram.dout[15:12];

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        issue    = 1'b0;
        wr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_line_req) begin
                    start    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (!psram.busy) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (psram.done) begin
                    wr       = 1'b1;
                    state_nx = last ? DONE : REQ;
                end
            end
            DONE: begin
                if (i_line_req) begin
                    start    = 1'b1;
                    state_nx = REQ;
                end else if (i_swap) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            front_sel  <= 1'b0;
            idx        <= '0;
            line_base  <= '0;
            psram.stb  <= 1'b0;
            psram.addr <= '0;
            o_err      <= 2'b00;
        end else begin
            psram.stb <= issue;
            if (issue) begin
                psram.addr <= line_base + 24'(idx);
            end
            if (start) begin
                line_base <= BASE_ADDR
                           + 24'(i_line_num) * 24'(LINE_WORDS);
                idx       <= '0;
            end else if (wr && !last) begin
                idx <= idx + 1'b1;
            end
            if (i_swap) begin
                front_sel <= ~front_sel;
            end
            if (drop) begin
                o_err[0] <= 1'b1;
            end
            if (underrun) begin
                o_err[1] <= 1'b1;
            end
        end
    end

    // Writes always target whichever bank is not being displayed right now.
    always_ff @(posedge clk_100mhz) begin
        if (wr) begin
            if (front_sel) begin
                bank0[idx] <= psram.dout[11:0];
            end else begin
                bank1[idx] <= psram.dout[11:0];
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            o_pix_color <= 12'h000;
        end else if (int'(i_pix_x) >= LINE_WORDS) begin
            o_pix_color <= 12'h000;
        end else if (front_sel) begin
            o_pix_color <= bank1[rd_idx];
        end else begin
            o_pix_color <= bank0[rd_idx];
        end
    end
endmodule

// File: tb/tb_scanline_fetcher.sv
// tb_scanline_fetcher: randomized fetch scenarios against a PSRAM responder
// and a two-bank line model kept in the bench.
module tb_scanline_fetcher;
  localparam int LW = 640;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic line_req = 1'b0;
  logic swap = 1'b0;
  logic [8:0] line_num = '0;
  logic [9:0] pix_x = '0;
  logic line_ready;
  logic [11:0] pix_color;
  logic [1:0] err;

  logic w_req = 1'b0;
  logic w_swap = 1'b0;
  logic [8:0] w_num = '0;
  logic [9:0] w_pix = '0;
  logic w_ready;
  logic [11:0] w_color;
  logic [1:0] w_err;

  int checks = 0;
  int failures = 0;

  scanline_fetcher_if pm();
  scanline_fetcher_if pw();

  always #5 clk = ~clk;

  scanline_fetcher u_dut (
    .clk_100mhz  (clk),
    .rstn_i      (rstn),
    .i_line_req  (line_req),
    .i_line_num  (line_num),
    .i_swap      (swap),
    .o_line_ready(line_ready),
    .psram       (pm),
    .i_pix_x     (pix_x),
    .o_pix_color (pix_color),
    .o_err       (err)
  );

  scanline_fetcher #(.BASE_ADDR(24'hFFFF00)) u_wrap (
    .clk_100mhz  (clk),
    .rstn_i      (rstn),
    .i_line_req  (w_req),
    .i_line_num  (w_num),
    .i_swap      (w_swap),
    .o_line_ready(w_ready),
    .psram       (pw),
    .i_pix_x     (w_pix),
    .o_pix_color (w_color),
    .o_err       (w_err)
  );

  // Model state: banks indexed by model front/back, fetch logs.
  int lat_m = 4;
  bit pat_m = 0;
  bit live_m = 0;
  bit mfront = 0;
  int cnt_m = 0;
  logic [15:0] pend_m;
  logic [23:0] aq[$];
  logic [15:0] wq[$];
  logic [11:0] mb [2][LW];
  logic [1:0] exp_err = 2'b00;

  int cnt_w = 0;
  logic [15:0] pend_w;
  logic [23:0] waq[$];
  logic [15:0] wwq[$];

  always @(negedge clk) begin
    pm.done = 1'b0;
    if (cnt_m > 0) begin
      cnt_m--;
      if (cnt_m == 0) begin
        pm.done = 1'b1;
        pm.dout = pend_m;
        if (live_m && wq.size() < LW) begin
          mb[!mfront][wq.size()] = pend_m[11:0];
          wq.push_back(pend_m);
        end
      end
    end
    if (rstn && pm.stb) begin
      pend_m = pat_m ? (16'hF000 | 16'(aq.size())) : 16'($urandom);
      aq.push_back(pm.addr);
      cnt_m = (lat_m > 0) ? lat_m : int'($urandom_range(6, 1));
    end
  end

  always @(negedge clk) begin
    pw.done = 1'b0;
    if (cnt_w > 0) begin
      cnt_w--;
      if (cnt_w == 0) begin
        pw.done = 1'b1;
        pw.dout = pend_w;
        wwq.push_back(pend_w);
      end
    end
    if (rstn && pw.stb) begin
      pend_w = 16'($urandom);
      waq.push_back(pw.addr);
      cnt_w = 2;
    end
  end

  function automatic int bad_addrs(input logic [23:0] q[$],
                                   input logic [23:0] base);
    int bad = 0;
    for (int k = 0; k < q.size(); k++)
      if (q[k] !== 24'(base + 24'(k))) bad++;
    return bad;
  endfunction

  task automatic start_fetch(input logic [8:0] ln);
    aq.delete();
    wq.delete();
    live_m = 1;
    @(negedge clk);
    line_req = 1'b1;
    line_num = ln;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic do_swap();
    @(negedge clk);
    swap = 1'b1;
    @(posedge clk);
    mfront = ~mfront;
    @(negedge clk);
    swap = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (line_ready) ok = 1;
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (wq.size() >= n) ok = 1;
    end
  endtask

  task automatic read_pix(input logic [9:0] x, output logic [11:0] c);
    @(negedge clk);
    pix_x = x;
    @(negedge clk);
    c = pix_color;
  endtask

  task automatic test_reset();
    bit ok;
    int stbs;
    lat_m = 4;
    pat_m = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pm.stb, pm.we, pm.addr, line_ready, err, pix_color} !== '0) begin
      failures++;
      $display("FAIL reset_outputs stb=%b we=%b addr=%h rdy=%b err=%b col=%h want all 0",
               pm.stb, pm.we, pm.addr, line_ready, err, pix_color);
    end
    @(negedge clk);
    rstn = 1'b1;
    start_fetch(9'd7);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (pm.stb && aq.size() >= 19) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_prefetch_timeout stb_count=%0d want>=20", aq.size());
    end
    @(negedge clk);
    #1;
    live_m = 0;
    rstn = 1'b0;
    mfront = 0;
    exp_err = 2'b00;
    @(posedge clk);
    #1;
    checks++;
    if ({pm.stb, pm.addr, line_ready, err, pix_color} !== '0) begin
      failures++;
      $display("FAIL reset_midfetch stb=%b addr=%h rdy=%b err=%b col=%h want all 0",
               pm.stb, pm.addr, line_ready, err, pix_color);
    end
    @(negedge clk);
    #1;
    rstn = 1'b1;
    stbs = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (pm.stb) stbs++;
    end
    checks++;
    if (stbs != 0) begin
      failures++;
      $display("FAIL reset_no_stb got=%0d want=0", stbs);
    end
    checks++;
    if ({line_ready, err, pm.addr} !== '0) begin
      failures++;
      $display("FAIL reset_after_late_done rdy=%b err=%b addr=%h want 0",
               line_ready, err, pm.addr);
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    logic [11:0] c;
    logic [9:0] x;
    lat_m = 4;
    pat_m = 1;
    start_fetch(9'd3);
    checks++;
    if (pm.stb !== 1'b0) begin
      failures++;
      $display("FAIL single_stb_early got=%b want=0", pm.stb);
    end
    @(negedge clk);
    checks++;
    if (pm.stb !== 1'b1 || pm.addr !== 24'd1920) begin
      failures++;
      $display("FAIL single_first_stb stb=%b addr=%0d want 1/1920", pm.stb, pm.addr);
    end
    wait_ready(ok);
    checks++;
    if (!ok || pm.done !== 1'b1 || wq.size() != LW) begin
      failures++;
      $display("FAIL single_ready ok=%b done=%b words=%0d want 1/1/%0d",
               ok, pm.done, wq.size(), LW);
    end
    bad = bad_addrs(aq, 24'd1920);
    checks++;
    if (aq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL single_addrs stbs=%0d bad=%0d want %0d/0", aq.size(), bad, LW);
    end
    do_swap();
    @(posedge clk);
    #1;
    checks++;
    if (line_ready !== 1'b0 || err !== exp_err) begin
      failures++;
      $display("FAIL single_after_swap rdy=%b err=%b want 0/%b", line_ready, err, exp_err);
    end
    read_pix(10'd5, c);
    checks++;
    if (c !== 12'h005) begin
      failures++;
      $display("FAIL single_pix5 got=%h want=005", c);
    end
    for (int i = 0; i < 6; i++) begin
      x = 10'($urandom_range(LW - 1, 0));
      read_pix(x, c);
      checks++;
      if (c !== 12'(x)) begin
        failures++;
        $display("FAIL single_pix x=%0d got=%h want=%h", x, c, 12'(x));
      end
    end
  endtask

  task automatic test_busy_stall();
    bit ok;
    int stbs;
    int bad;
    logic [8:0] ln;
    logic [23:0] base;
    logic [11:0] c;
    logic [9:0] x;
    lat_m = 0;
    pat_m = 0;
    ln = 9'($urandom_range(479, 0));
    base = 24'(ln) * 24'(LW);
    start_fetch(ln);
    wait_words(100, ok);
    pm.busy = 1'b1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL busy_reach_timeout words=%0d want=100", wq.size());
    end
    stbs = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (pm.stb) stbs++;
    end
    checks++;
    if (stbs != 0 || aq.size() != 100) begin
      failures++;
      $display("FAIL busy_stall stbs=%0d total=%0d want 0/100", stbs, aq.size());
    end
    pm.busy = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pm.stb !== 1'b1 || pm.addr !== base + 24'd100) begin
      failures++;
      $display("FAIL busy_resume stb=%b addr=%h want 1/%h", pm.stb, pm.addr, base + 24'd100);
    end
    wait_ready(ok);
    bad = bad_addrs(aq, base);
    checks++;
    if (!ok || aq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL busy_fetch ok=%b stbs=%0d bad=%0d want 1/%0d/0", ok, aq.size(), bad, LW);
    end
    do_swap();
    for (int i = 0; i < 6; i++) begin
      x = 10'($urandom_range(LW - 1, 0));
      read_pix(x, c);
      checks++;
      if (c !== mb[mfront][x]) begin
        failures++;
        $display("FAIL busy_pix x=%0d got=%h want=%h", x, c, mb[mfront][x]);
      end
    end
  endtask

  task automatic test_dropped_req();
    bit ok;
    int bad;
    logic [8:0] ln;
    logic [11:0] c;
    logic [9:0] x;
    lat_m = 0;
    ln = 9'($urandom_range(239, 0));
    start_fetch(ln);
    wait_words(10, ok);
    @(negedge clk);
    line_req = 1'b1;
    line_num = ln + 9'd200;
    @(negedge clk);
    line_req = 1'b0;
    exp_err[0] = 1'b1;
    checks++;
    if (!ok || err !== exp_err) begin
      failures++;
      $display("FAIL drop_err ok=%b err=%b want 1/%b", ok, err, exp_err);
    end
    wait_ready(ok);
    bad = bad_addrs(aq, 24'(ln) * 24'(LW));
    checks++;
    if (!ok || aq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL drop_fetch ok=%b stbs=%0d bad=%0d want 1/%0d/0", ok, aq.size(), bad, LW);
    end
    do_swap();
    for (int i = 0; i < 6; i++) begin
      x = 10'($urandom_range(LW - 1, 0));
      read_pix(x, c);
      checks++;
      if (c !== mb[mfront][x]) begin
        failures++;
        $display("FAIL drop_pix x=%0d got=%h want=%h", x, c, mb[mfront][x]);
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int bad;
    logic [8:0] ln;
    logic [11:0] c;
    logic [9:0] x;
    lat_m = 0;
    ln = 9'($urandom_range(479, 0));
    start_fetch(ln);
    wait_words(300, ok);
    do_swap();
    exp_err[1] = 1'b1;
    checks++;
    if (!ok || err !== exp_err || line_ready !== 1'b0) begin
      failures++;
      $display("FAIL underrun_err ok=%b err=%b rdy=%b want 1/%b/0", ok, err, line_ready, exp_err);
    end
    wait_ready(ok);
    bad = bad_addrs(aq, 24'(ln) * 24'(LW));
    checks++;
    if (!ok || aq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL underrun_fetch ok=%b stbs=%0d bad=%0d want 1/%0d/0", ok, aq.size(), bad, LW);
    end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        x = (i < 3) ? 10'($urandom_range(299, 0)) : 10'($urandom_range(LW - 1, 300));
        read_pix(x, c);
        checks++;
        if (c !== mb[mfront][x]) begin
          failures++;
          $display("FAIL underrun_pix s=%0d x=%0d got=%h want=%h", s, x, c, mb[mfront][x]);
        end
      end
      if (s == 0) do_swap();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    logic [8:0] ln2;
    logic [11:0] c;
    logic [9:0] x;
    lat_m = 0;
    start_fetch(9'($urandom_range(479, 0)));
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_first_ready got=%b want=1", line_ready);
    end
    ln2 = 9'($urandom_range(479, 0));
    @(negedge clk);
    aq.delete();
    wq.delete();
    swap = 1'b1;
    line_req = 1'b1;
    line_num = ln2;
    @(posedge clk);
    mfront = ~mfront;
    @(negedge clk);
    swap = 1'b0;
    line_req = 1'b0;
    checks++;
    if (line_ready !== 1'b0 || err !== exp_err) begin
      failures++;
      $display("FAIL b2b_restart rdy=%b err=%b want 0/%b", line_ready, err, exp_err);
    end
    wait_ready(ok);
    bad = bad_addrs(aq, 24'(ln2) * 24'(LW));
    checks++;
    if (!ok || aq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL b2b_fetch ok=%b stbs=%0d bad=%0d want 1/%0d/0", ok, aq.size(), bad, LW);
    end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        x = 10'($urandom_range(LW - 1, 0));
        read_pix(x, c);
        checks++;
        if (c !== mb[mfront][x]) begin
          failures++;
          $display("FAIL b2b_pix s=%0d x=%0d got=%h want=%h", s, x, c, mb[mfront][x]);
        end
      end
      if (s == 0) do_swap();
    end
  endtask

  task automatic test_wrap_bounds();
    bit ok;
    int bad;
    logic [11:0] c;
    logic [9:0] x;
    read_pix(10'd700, c);
    checks++;
    if (c !== 12'h000) begin
      failures++;
      $display("FAIL bounds_700 got=%h want=000", c);
    end
    read_pix(10'd640, c);
    checks++;
    if (c !== 12'h000) begin
      failures++;
      $display("FAIL bounds_640 got=%h want=000", c);
    end
    @(negedge clk);
    w_req = 1'b1;
    w_num = 9'd0;
    @(negedge clk);
    w_req = 1'b0;
    ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (w_ready) ok = 1;
    end
    bad = bad_addrs(waq, 24'hFFFF00);
    checks++;
    if (!ok || waq.size() != LW || wwq.size() != LW || bad != 0) begin
      failures++;
      $display("FAIL wrap_fetch ok=%b stbs=%0d bad=%0d want 1/%0d/0", ok, waq.size(), bad, LW);
    end
    checks++;
    if (waq.size() > 256 && (waq[255] !== 24'hFFFFFF || waq[256] !== 24'h000000)) begin
      failures++;
      $display("FAIL wrap_edge got=%h,%h want=ffffff,000000", waq[255], waq[256]);
    end
    @(negedge clk);
    w_swap = 1'b1;
    @(negedge clk);
    w_swap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = (i == 0) ? 10'd256 : 10'($urandom_range(LW - 1, 0));
      @(negedge clk);
      w_pix = x;
      @(negedge clk);
      checks++;
      if (int'(x) < wwq.size() && w_color !== wwq[x][11:0]) begin
        failures++;
        $display("FAIL wrap_pix x=%0d got=%h want=%h", x, w_color, wwq[x][11:0]);
      end
    end
    @(negedge clk);
    w_pix = 10'd700;
    @(negedge clk);
    checks++;
    if (w_color !== 12'h000 || w_err !== 2'b00) begin
      failures++;
      $display("FAIL wrap_bounds col=%h err=%b want 000/00", w_color, w_err);
    end
  endtask

  initial begin
    pm.busy = 1'b0;
    pw.busy = 1'b0;
    test_reset();
    test_single();
    test_busy_stall();
    test_dropped_req();
    test_underrun();
    test_back_to_back();
    test_wrap_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
